scoreboard_regfile: RTL and testbench
=====================================

Name: scoreboard_regfile

Overview:
Parametrised successor of the core's integer register file. It provides NREAD combinational read ports, one write port with same-cycle write-to-read bypass, and a per-register busy scoreboard for in-flight destinations. A post-reset clearing sequencer zeroes every entry in hardware instead of relying on initial blocks. It sits between decode/issue (reads, busy set) and writeback (write, busy clear).

Parameters:
AWIDTH, 5, register address width; depth = 2**AWIDTH
DWIDTH, 32, register data width
NREAD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = entry 0 hardwired to zero and never busy; 0 = entry 0 is ordinary

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
ready  out  1  high once the clear sequence is done; read, write and issue are valid only when high
wen  in  1  write enable (writeback)
waddr  in  AWIDTH  write address
wdata  in  DWIDTH  write data
set_en  in  1  issue marks set_addr busy
set_addr  in  AWIDTH  destination being issued
raddr  in  NREAD*AWIDTH  read addresses; port i = bits [i*AWIDTH +: AWIDTH]
rdata  out  NREAD*DWIDTH  read data; port i = bits [i*DWIDTH +: DWIDTH]
rbusy  out  NREAD  busy flag per read port

Behaviour:
- Reset and clear sequencer states: CLEAR, READY.
  - Any edge with rst=1: state<=CLEAR, idx<=0, all busy bits<=0. Memory is untouched while rst is high.
  - In CLEAR with rst=0, each edge: mem[idx]<=0, idx<=idx+1. The edge that clears entry 2**AWIDTH-1 moves state to READY.
  - ready rises after exactly 2**AWIDTH edges with rst=0 (32 for the default).
  - rst reasserted mid-clear or in READY restarts from idx=0.
- While ready=0: rdata=0, rbusy=0; wen and set_en are ignored.
- Write (ready=1): effective write we = wen & ~(ZERO_REG & waddr==0); mem[waddr]<=wdata on the edge.
- Read, combinational, zero cycles latency, per port i:
  - ZERO_REG and raddr_i==0: rdata_i=0.
  - Else if we and waddr==raddr_i: rdata_i=wdata (bypass).
  - Else rdata_i=mem[raddr_i].
- Scoreboard (ready=1):
  - Edge with we: busy[waddr]<=0.
  - Edge with set_en and not (ZERO_REG & set_addr==0): busy[set_addr]<=1.
  - set and clear on the same address in the same cycle: set wins, so the new producer stays pending.
  - rbusy_i = busy[raddr_i] & ~(we & waddr==raddr_i), so bypassed data reads not busy. Forced to 0 for entry 0 when ZERO_REG.
- Write to a non-busy register is legal and leaves busy unchanged at 0. set_en on an already-busy register keeps it at 1.
- All read ports are independent; identical addresses on several ports return identical results.

Optional Feature:
REGFILE_TRACE_EN
- Defined: on every edge with an effective write, $display prints the cycle count, waddr and wdata. The cycle count is a 64-bit counter cleared by rst, and it is compiled in only under this macro. When the clear sequencer reaches READY, a one-time "regfile ready" line is printed.
- Undefined: no display statements and no trace counter; logic is otherwise identical.

Test Plan:
- rst=1 for 3 cycles then 0 -> ready=0 for 32 edges, ready=1 after the 32nd; then every raddr returns rdata=0 and rbusy=0.
- Write 5 <- 0xDEADBEEF while raddr0=5 in the same cycle -> rdata0=0xDEADBEEF combinationally (bypass); next cycle with wen=0 -> rdata0 still 0xDEADBEEF from mem.
- wen=1 waddr=0 wdata=0x1234, set_en set_addr=0 (ZERO_REG=1) -> rdata for addr 0 stays 0, rbusy stays 0.
- set_en addr 7 -> next cycle rbusy=1 for raddr=7. Then wen addr 7 plus set_en addr 7 in the same cycle -> busy remains 1. Then wen alone -> rbusy=0 during that cycle (bypass) and after.
- Reassert rst at clear idx=10, then release -> ready rises exactly 32 edges later, not 22. Busy bits set before reset read 0.
- Writes/set_en during CLEAR (addr 3, 0xFF) -> ignored; after ready, addr 3 reads 0 and is not busy.

Source files
------------

// File: rtl/scoreboard_regfile.sv
// scoreboard_regfile: NREAD-port register file with write bypass, busy scoreboard, hardware clear; REGFILE_TRACE_EN adds write trace
module scoreboard_regfile #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 32,
  parameter int NREAD = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     ready,
  input  logic                     wen,
  input  logic [AWIDTH-1:0]        waddr,
  input  logic [DWIDTH-1:0]        wdata,
  input  logic                     set_en,
  input  logic [AWIDTH-1:0]        set_addr,
  input  logic [NREAD*AWIDTH-1:0]  raddr,
  output logic [NREAD*DWIDTH-1:0]  rdata,
  output logic [NREAD-1:0]         rbusy
);
  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] READY = 1'b1;
  logic [0:0] state;
  logic [AWIDTH-1:0] idx;
  logic [DWIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic we, se;
  assign ready = state == READY;
  assign we = ready && wen && !(ZERO_REG != 0 && waddr == '0);
  assign se = ready && set_en && !(ZERO_REG != 0 && set_addr == '0);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      idx <= '0;
      busy <= '0;
    end else if (state == CLEAR) begin
      idx <= idx + AWIDTH'(1);
      if (&idx) state <= READY;
    end else begin
      if (we) busy[waddr] <= 1'b0;
      if (se) busy[set_addr] <= 1'b1;
    end
  end
  // memory has no reset so it can map onto RAM; the sequencer zeroes it instead
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!ready) mem[idx] <= '0;
      else if (we) mem[waddr] <= wdata;
    end
  end
  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AWIDTH-1:0] ra;
    logic zero, hit;
    assign ra = raddr[i*AWIDTH +: AWIDTH];
    assign zero = ZERO_REG != 0 && ra == '0;
    assign hit = we && waddr == ra;
    assign rdata[i*DWIDTH +: DWIDTH] = (!ready || zero) ? '0 : hit ? wdata : mem[ra];
    assign rbusy[i] = ready && !zero && !hit && busy[ra];
  end
`ifdef REGFILE_TRACE_EN
  logic [63:0] cycles;
  always_ff @(posedge clk) begin
    cycles <= rst ? '0 : cycles + 64'd1;
    if (!rst && we) $display("regfile cycle %0d write x%0d = %h", cycles, waddr, wdata);
    if (!rst && state == CLEAR && &idx) $display("regfile ready");
  end
`endif
endmodule

// File: tb/tb_scoreboard_regfile.sv
// tb_scoreboard_regfile: vector table, reset/clear sequences and randomized traffic against a reference model
module tb_scoreboard_regfile;
  localparam int AW = 5, DW = 32, NR = 2, DEPTH = 32;
  logic clk = 0, rst = 1, wen = 0, set_en = 0;
  logic [AW-1:0] waddr = '0, set_addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [NR*AW-1:0] raddr = '0;
  logic ready;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0] rbusy;
  int checks = 0, errors = 0;

  scoreboard_regfile #(.AWIDTH(AW), .DWIDTH(DW), .NREAD(NR), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .ready(ready), .wen(wen), .waddr(waddr), .wdata(wdata),
    .set_en(set_en), .set_addr(set_addr), .raddr(raddr), .rdata(rdata), .rbusy(rbusy)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] m_mem [DEPTH];
  bit m_busy [DEPTH];
  int m_cnt = 0;
  bit m_ready = 0;

  function automatic bit m_we();
    return m_ready && wen && waddr != 0;
  endfunction

  function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] a);
    if (!m_ready || a == 0) return '0;
    if (m_we() && waddr == a) return wdata;
    return m_mem[a];
  endfunction

  function automatic bit m_rb(input logic [AW-1:0] a);
    return m_ready && a != 0 && m_busy[a] && !(m_we() && waddr == a);
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_cnt = 0;
      m_ready = 0;
      foreach (m_busy[i]) m_busy[i] = 0;
    end else if (!m_ready) begin
      m_cnt++;
      if (m_cnt == DEPTH) begin
        m_ready = 1;
        foreach (m_mem[i]) m_mem[i] = '0;
      end
    end else begin
      if (m_we()) begin
        m_mem[waddr] = wdata;
        m_busy[waddr] = 0;
      end
      if (set_en && set_addr != 0) m_busy[set_addr] = 1;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_model(input string name);
    logic [NR*DW-1:0] ed;
    logic [NR-1:0] eb;
    #1;
    for (int p = 0; p < NR; p++) begin
      ed[p*DW +: DW] = m_rd(raddr[p*AW +: AW]);
      eb[p] = m_rb(raddr[p*AW +: AW]);
    end
    chk({name, "_ready"}, 64'(ready), 64'(m_ready));
    chk({name, "_rdata"}, 64'(rdata), 64'(ed));
    chk({name, "_rbusy"}, 64'(rbusy), 64'(eb));
  endtask

  typedef struct {
    logic wen; logic [AW-1:0] waddr; logic [DW-1:0] wdata;
    logic set_en; logic [AW-1:0] set_addr;
    logic [AW-1:0] ra0, ra1;
    logic [DW-1:0] e0, e1; logic [1:0] eb;
  } vec_t;
  vec_t tbl [10];

  initial begin
    int n;
    tbl[0] = '{1, 5, 32'hDEADBEEF, 0, 0, 5, 3, 32'hDEADBEEF, 32'h0, 2'b00};
    tbl[1] = '{0, 0, 32'h0, 0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00};
    tbl[2] = '{1, 0, 32'h1234, 1, 0, 0, 5, 32'h0, 32'hDEADBEEF, 2'b00};
    tbl[3] = '{0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0, 2'b00};
    tbl[4] = '{0, 0, 32'h0, 1, 7, 7, 5, 32'h0, 32'hDEADBEEF, 2'b00};
    tbl[5] = '{0, 0, 32'h0, 0, 0, 7, 7, 32'h0, 32'h0, 2'b11};
    tbl[6] = '{1, 7, 32'hAA, 1, 7, 7, 5, 32'hAA, 32'hDEADBEEF, 2'b00};
    tbl[7] = '{0, 0, 32'h0, 0, 0, 7, 7, 32'hAA, 32'hAA, 2'b11};
    tbl[8] = '{1, 7, 32'hBB, 0, 0, 7, 7, 32'hBB, 32'hBB, 2'b00};
    tbl[9] = '{0, 0, 32'h0, 0, 0, 7, 0, 32'hBB, 32'h0, 2'b00};

    rst = 1;
    repeat (3) tick();
    rst = 0;
    wen = 1; waddr = 3; wdata = 32'hFF; set_en = 1; set_addr = 3; raddr = {AW'(3), AW'(3)};
    for (int e = 0; e < DEPTH; e++) begin
      chk("clear_ready", 64'(ready), 64'(0));
      chk("clear_rdata", 64'(rdata), 64'(0));
      tick();
    end
    chk("ready_after_32", 64'(ready), 64'(1));
    wen = 0; set_en = 0;
    #1;
    chk("addr3_rdata", 64'(rdata[DW-1:0]), 64'(0));
    chk("addr3_rbusy", 64'(rbusy), 64'(0));
    for (int a = 0; a < DEPTH; a++) begin
      raddr = {AW'(DEPTH - 1 - a), AW'(a)};
      #1;
      chk("sweep_rdata", 64'(rdata), 64'(0));
      chk("sweep_rbusy", 64'(rbusy), 64'(0));
    end

    foreach (tbl[k]) begin
      wen = tbl[k].wen; waddr = tbl[k].waddr; wdata = tbl[k].wdata;
      set_en = tbl[k].set_en; set_addr = tbl[k].set_addr;
      raddr = {tbl[k].ra1, tbl[k].ra0};
      #1;
      chk($sformatf("vec%0d_rdata0", k), 64'(rdata[DW-1:0]), 64'(tbl[k].e0));
      chk($sformatf("vec%0d_rdata1", k), 64'(rdata[2*DW-1:DW]), 64'(tbl[k].e1));
      chk($sformatf("vec%0d_rbusy", k), 64'(rbusy), 64'(tbl[k].eb));
      chk_model($sformatf("vec%0d_model", k));
      tick();
    end
    wen = 0; set_en = 0;

    set_en = 1; set_addr = 9; tick();
    set_addr = 12; tick();
    set_en = 0; raddr = {AW'(12), AW'(9)};
    #1;
    chk("pre_rst_busy", 64'(rbusy), 64'(2'b11));
    rst = 1; tick();
    rst = 0;
    repeat (10) tick();
    rst = 1; tick();
    rst = 0;
    n = 0;
    while (!ready && n < 40) begin
      tick();
      n++;
    end
    chk("restart_len", 64'(n), 64'(32));
    #1;
    chk("post_rst_busy", 64'(rbusy), 64'(0));
    chk("post_rst_rdata", 64'(rdata), 64'(0));
    chk_model("post_rst_model");

    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 999) == 0);
      wen = $urandom_range(0, 1);
      waddr = $urandom_range(0, 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      wdata = $urandom;
      set_en = ($urandom_range(0, 2) == 0);
      set_addr = $urandom_range(0, 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      for (int p = 0; p < NR; p++)
        raddr[p*AW +: AW] = $urandom_range(0, 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      if ($urandom_range(0, 3) == 0) raddr[AW-1:0] = waddr;
      chk_model("rand");
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
